pc_sequencer: RTL and testbench

- Parametrised next-generation program-counter unit for the fetch stage.
- Holds the current PC and advances by a configurable step.
- Selects among sequential, branch, call, return and flush redirects under fixed priority.
- Contains an internal circular return-address stack (RAS) that supplies return targets without a register-file read.

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/ras_stack.sv | 72 +++++++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types for the program-counter sequencer.
//   addr_t    : default-width address type (ADDR_W default = 24)
//   sel_t     : next-PC source select
//   RAS_PTR_W : pointer width for the default RAS depth
package pc_seq_pkg;
    localparam int ADDR_W_DEF    = 24;
    localparam int RAS_DEPTH_DEF = 8;
    localparam int RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

    typedef logic [ADDR_W_DEF-1:0] addr_t;

    typedef enum logic [1:0] {
        SEL_SEQ   = 2'd0,
        SEL_BR    = 2'd1,
        SEL_RET   = 2'd2,
        SEL_FLUSH = 2'd3
    } sel_t;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating count.
//   clk, rst (sync, active-low)
//   en      : qualifies push/pop/replace
//   push    : advance top, write din at new top
//   pop     : retreat top (dout is the entry being popped)
//   replace : overwrite current top with din, pointer/count unchanged
//   dout    : current top entry
//   count   : number of valid entries, saturates at DEPTH
// When full, a push wraps the pointer onto the oldest entry and overwrites it.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int W     = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     replace,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          wr_en;
    logic [PW-1:0] wr_idx;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (en) begin
            if (replace) begin
                wr_en = 1'b1;
            end else if (push) begin
                ptr_d  = ptr_q + 1'b1;
                wr_idx = ptr_q + 1'b1;
                wr_en  = 1'b1;
                if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
            end else if (pop && cnt_q != '0) begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= din;
    end

    assign dout  = mem_q[ptr_q];
    assign count = cnt_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with redirect priority
// flush > branch(+call) > ret > sequential, and an internal RAS.
//   clk, rst (sync, active-low), en (0 = stall, flush still acts)
//   flush_flag/flush_addr, branch_flag/branch_addr, call_flag, ret_flag
//   pc (registered), pc_plus (pc+STEP, comb), ras_count/empty/full,
//   ras_underflow (pulse: ret on empty stack)
// Optional: PC_ALIGN_CHECK_EN adds registered pulse output misalign, set
// when a loaded flush/branch/ret target has nonzero low $clog2(STEP) bits.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          STEP      = 4,
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter int          RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush_flag,
    input  logic [ADDR_W-1:0]            flush_addr,
    input  logic                         branch_flag,
    input  logic [ADDR_W-1:0]            branch_addr,
    input  logic                         call_flag,
    input  logic                         ret_flag,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_empty,
    output logic                         ras_full,
`ifdef PC_ALIGN_CHECK_EN
    output logic                         misalign,
`endif
    output logic                         ras_underflow
);
    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RST_V  = RESET_PC[ADDR_W-1:0];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              underflow_q, underflow_d;
    logic              push, pop, replace;
    logic [ADDR_W-1:0] ras_dout;
    sel_t              sel;

    assign pc_plus   = pc_q + STEP_V;
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == ($clog2(RAS_DEPTH)+1)'(RAS_DEPTH));

    always_comb begin
        sel         = SEL_SEQ;
        push        = 1'b0;
        pop         = 1'b0;
        replace     = 1'b0;
        underflow_d = 1'b0;
        if (flush_flag) begin
            sel = SEL_FLUSH;
        end else if (branch_flag) begin
            sel = SEL_BR;
            // Tail call reuses the top slot; on an empty stack it is a push.
            if (call_flag) begin
                if (ret_flag && !ras_empty) replace = 1'b1;
                else                        push    = 1'b1;
            end
        end else if (ret_flag) begin
            if (!ras_empty) begin
                sel = SEL_RET;
                pop = 1'b1;
            end else begin
                underflow_d = en;
            end
        end

        case (sel)
            SEL_FLUSH: pc_d = flush_addr;
            SEL_BR:    pc_d = branch_addr;
            SEL_RET:   pc_d = ras_dout;
            default:   pc_d = pc_plus;
        endcase
        if (!en && !flush_flag) pc_d = pc_q;
    end

    ras_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
        .clk     (clk),
        .rst     (rst),
        .en      (en & ~flush_flag),
        .push    (push),
        .pop     (pop),
        .replace (replace),
        .din     (pc_plus),
        .dout    (ras_dout),
        .count   (ras_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RST_V;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    assign pc            = pc_q;
    assign ras_underflow = underflow_q;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = 1'b0;
        if ((flush_flag || en) && sel != SEL_SEQ)
            misalign_d = ((pc_d & ALIGN_MASK) != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst, en, flush_flag, branch_flag, call_flag, ret_flag;
    logic [23:0] flush_addr, branch_addr;
    logic [23:0] pc, pc_plus;
    logic [3:0]  ras_count;
    logic        ras_empty, ras_full, ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush_flag    (flush_flag),
        .flush_addr    (flush_addr),
        .branch_flag   (branch_flag),
        .branch_addr   (branch_addr),
        .call_flag     (call_flag),
        .ret_flag      (ret_flag),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
`ifdef PC_ALIGN_CHECK_EN
        .misalign      (misalign),
`endif
        .ras_underflow (ras_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        en = 1'b1; flush_flag = 1'b0; branch_flag = 1'b0; call_flag = 1'b0; ret_flag = 1'b0;
        flush_addr = '0; branch_addr = '0;
    endtask

    // Apply current inputs across one rising edge, then settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [23:0] a);
        idle(); flush_flag = 1'b1; flush_addr = a; tick(); idle();
    endtask

    task automatic do_call(input logic [23:0] a);
        idle(); branch_flag = 1'b1; call_flag = 1'b1; branch_addr = a; tick(); idle();
    endtask

    task automatic do_ret();
        idle(); ret_flag = 1'b1; tick(); idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_count", ras_count, 32'd0);
        chk("rst_empty", ras_empty, 32'd1);
        chk("rst_full", ras_full, 32'd0);
        chk("rst_uflow", ras_underflow, 32'd0);
        chk("rst_pc_plus", pc_plus, 32'h4);

        // Sequential advance
        rst = 1'b1;
        tick(); chk("seq_1", pc, 32'h4);
        tick(); chk("seq_2", pc, 32'h8);
        tick(); chk("seq_3", pc, 32'hC);
        chk("seq_empty", ras_empty, 32'd1);

        // Call and return
        do_flush(24'h100);
        chk("flush_100", pc, 32'h100);
        do_call(24'h400);
        chk("call_pc", pc, 32'h400);
        chk("call_count", ras_count, 32'd1);
        chk("call_pc_plus", pc_plus, 32'h404);
        do_ret();
        chk("ret_pc", pc, 32'h104);
        chk("ret_count", ras_count, 32'd0);

        // Nine nested calls into an 8-deep stack
        do_flush(24'h1000);
        for (int i = 0; i < 9; i++) begin
            do_call(24'h2000 + 24'(i * 16));
            chk("nest_count", ras_count, (i + 1 > 8) ? 32'd8 : 32'(i + 1));
        end
        chk("nest_full", ras_full, 32'd1);
        for (int k = 0; k < 8; k++) begin
            do_ret();
            chk("nest_ret_pc", pc, 32'h2000 + 32'((7 - k) * 16) + 32'h4);
        end
        chk("nest_drained", ras_count, 32'd0);
        chk("nest_empty", ras_empty, 32'd1);

        // Return on empty stack
        do_flush(24'h20);
        idle(); ret_flag = 1'b1; tick();
        chk("uflow_pc", pc, 32'h24);
        chk("uflow_pulse", ras_underflow, 32'd1);
        chk("uflow_count", ras_count, 32'd0);
        idle(); tick();
        chk("uflow_clear", ras_underflow, 32'd0);
        chk("uflow_seq", pc, 32'h28);

        // Stall and flush-under-stall; RAS must keep its entry
        do_call(24'h40);
        chk("stall_pre_count", ras_count, 32'd1);
        idle(); en = 1'b0; branch_flag = 1'b1; branch_addr = 24'h500; ret_flag = 1'b1; tick();
        chk("stall_pc", pc, 32'h40);
        chk("stall_count", ras_count, 32'd1);
        idle(); en = 1'b0; flush_flag = 1'b1; flush_addr = 24'h800; ret_flag = 1'b1; tick();
        chk("stall_flush_pc", pc, 32'h800);
        chk("stall_flush_count", ras_count, 32'd1);
        do_ret();
        chk("stall_ret_pc", pc, 32'h2C);

        // Tail call replaces top; branch beats ret; lone call_flag ignored
        do_call(24'h300);
        idle(); branch_flag = 1'b1; call_flag = 1'b1; ret_flag = 1'b1; branch_addr = 24'h600; tick();
        chk("tail_pc", pc, 32'h600);
        chk("tail_count", ras_count, 32'd1);
        idle(); branch_flag = 1'b1; ret_flag = 1'b1; branch_addr = 24'h700; tick();
        chk("br_ret_pc", pc, 32'h700);
        chk("br_ret_count", ras_count, 32'd1);
        idle(); call_flag = 1'b1; tick();
        chk("lone_call_pc", pc, 32'h704);
        chk("lone_call_count", ras_count, 32'd1);
        do_ret();
        chk("tail_ret_pc", pc, 32'h304);
        chk("tail_ret_count", ras_count, 32'd0);

        // Address wrap, then reset mid call sequence
        do_flush(24'hFFFFFC);
        chk("wrap_plus", pc_plus, 32'h0);
        tick();
        chk("wrap_pc", pc, 32'h0);
        do_call(24'h100);
        chk("pre_rst_count", ras_count, 32'd1);
        idle(); rst = 1'b0; branch_flag = 1'b1; call_flag = 1'b1; branch_addr = 24'h900; tick();
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_count", ras_count, 32'd0);
        rst = 1'b1;
        idle(); tick();
        chk("post_rst_pc", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
